// File: rtl/sort_pkg.sv
// Shared types, default sizes and the compare-exchange primitive for serial_sorter.
// Defining SERIAL_SORTER_DESC_EN flips the exchange condition so batches come out descending.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    OUT
  } sorter_state_e;

  localparam int unsigned DEFAULT_N     = 5;
  localparam int unsigned DEFAULT_WIDTH = 6;
  // Widest element the compare-exchange function handles.
  localparam int unsigned MAX_W         = 32;

  // Returns {value for the lower index, value for the higher index}; equal values never swap.
  function automatic logic [2*MAX_W-1:0] cmp_exchange(input logic [MAX_W-1:0] a,
                                                      input logic [MAX_W-1:0] b);
`ifdef SERIAL_SORTER_DESC_EN
    return (a < b) ? {b, a} : {a, b};
`else
    return (a > b) ? {b, a} : {a, b};
`endif
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational WIDTH-bit compare-exchange cell, a thin wrapper around sort_pkg::cmp_exchange.
// Direction follows SERIAL_SORTER_DESC_EN through the package function.
module cmp_swap
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic [2*MAX_W-1:0] w_res;

  assign w_res = cmp_exchange(MAX_W'(i_a), MAX_W'(i_b));
  assign o_lo  = w_res[MAX_W +: WIDTH];
  assign o_hi  = w_res[0 +: WIDTH];

  // Zero-extension bits of the 32-bit result carry no information.
  if (WIDTH < MAX_W) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^{w_res[2*MAX_W-1:MAX_W+WIDTH], w_res[MAX_W-1:WIDTH]};
  end

endmodule

// File: rtl/serial_sorter.sv
// Loads N elements, sorts them with an N-phase odd-even transposition network, streams them out.
// Ascending by default; SERIAL_SORTER_DESC_EN (see sort_pkg) makes the output descending.
module serial_sorter
  import sort_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_num,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_num,
  output logic [CW-1:0]    out_idx,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int unsigned NP = N / 2;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  sorter_state_e    r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_buf [N];
  logic [WIDTH-1:0] w_buf_nxt [N];
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_num, w_out_num_nxt;
  logic [CW-1:0]    r_out_idx, w_out_idx_nxt;
  logic             r_out_last, w_out_last_nxt;

  logic             w_odd;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_a  [NP];
  logic [WIDTH-1:0] w_b  [NP];
  logic [WIDTH-1:0] w_lo [NP];
  logic [WIDTH-1:0] w_hi [NP];
  logic [WIDTH-1:0] w_ev [N];
  logic [WIDTH-1:0] w_od [N];
  logic [WIDTH-1:0] w_net [N];

  assign w_odd = r_cnt[0];
  assign w_idx = r_cnt[IW-1:0];

  // Each comparator serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases.
  for (genvar k = 0; k < NP; k++) begin : g_pair
    if (2 * k + 2 < N) begin : g_odd_ok
      assign w_a[k] = w_odd ? r_buf[2*k+1] : r_buf[2*k];
      assign w_b[k] = w_odd ? r_buf[2*k+2] : r_buf[2*k+1];
    end else begin : g_odd_na
      assign w_a[k] = r_buf[2*k];
      assign w_b[k] = r_buf[2*k+1];
    end
    cmp_swap #(
      .WIDTH(WIDTH)
    ) u_cmp_swap (
      .i_a (w_a[k]),
      .i_b (w_b[k]),
      .o_lo(w_lo[k]),
      .o_hi(w_hi[k])
    );
  end

  // Route comparator outputs back to buffer slots; unpaired slots keep their value.
  for (genvar i = 0; i < N; i++) begin : g_elem
    if (i < 2 * NP) begin : g_ev_pair
      if (i % 2 == 0) begin : g_ev_lo
        assign w_ev[i] = w_lo[i/2];
      end else begin : g_ev_hi
        assign w_ev[i] = w_hi[i/2];
      end
    end else begin : g_ev_keep
      assign w_ev[i] = r_buf[i];
    end
    if ((i % 2 == 1) && (i + 1 < N)) begin : g_od_lo
      assign w_od[i] = w_lo[(i-1)/2];
    end else if ((i % 2 == 0) && (i > 0)) begin : g_od_hi
      assign w_od[i] = w_hi[(i-2)/2];
    end else begin : g_od_keep
      assign w_od[i] = r_buf[i];
    end
    assign w_net[i] = w_odd ? w_od[i] : w_ev[i];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_buf_nxt       = r_buf;
    w_out_valid_nxt = r_out_valid;
    w_out_num_nxt   = r_out_num;
    w_out_idx_nxt   = r_out_idx;
    w_out_last_nxt  = r_out_last;
    unique case (r_state)
      LOAD: begin
        if (in_valid) begin
          w_buf_nxt[w_idx] = in_num;
          if (r_cnt == CW'(N - 1)) begin
            w_state_nxt = SORT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      SORT: begin
        w_buf_nxt = w_net;
        if (r_cnt == CW'(N - 1)) begin
          w_state_nxt = OUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      OUT: begin
        // r_cnt points at the next element to present, one ahead of out_idx.
        if (r_out_valid && out_ready && r_out_last) begin
          w_state_nxt     = LOAD;
          w_cnt_nxt       = '0;
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
        end else if (!r_out_valid || out_ready) begin
          w_out_valid_nxt = 1'b1;
          w_out_num_nxt   = r_buf[w_idx];
          w_out_idx_nxt   = r_cnt;
          w_out_last_nxt  = (r_cnt == CW'(N - 1));
          w_cnt_nxt       = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_buf       <= '{default: '0};
      r_out_valid <= 1'b0;
      r_out_num   <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf       <= w_buf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_num   <= w_out_num_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign in_ready  = (r_state == LOAD);
  assign out_valid = r_out_valid;
  assign out_num   = r_out_num;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_serial_sorter.sv
// Directed bench for serial_sorter; expectations follow SERIAL_SORTER_DESC_EN when defined.
module tb_serial_sorter;
  localparam int N  = 5;
  localparam int W  = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_num;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_num;
  logic [CW-1:0] out_idx;
  logic          out_last;
  logic          out_ready;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] v [N];
  logic [W-1:0] e [N];

  serial_sorter #(.N(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_num   (in_num),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_num  (out_num),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Stimulus only: returns 1 ns after the edge that accepts the last element.
  task automatic load_vals(input logic [W-1:0] vals [N], input int gap);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_num   = vals[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < N - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_num = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, out_num, out_idx, out_last} !== {1'b1, 1'b0, 6'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset got rdy=%b vld=%b num=%0d idx=%0d last=%b exp 1 0 0 0 0",
               in_ready, out_valid, out_num, out_idx, out_last);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    v = '{6'd9, 6'd3, 6'd60, 6'd3, 6'd0};
`ifdef SERIAL_SORTER_DESC_EN
    e = '{6'd60, 6'd9, 6'd3, 6'd3, 6'd0};
`else
    e = '{6'd0, 6'd3, 6'd3, 6'd9, 6'd60};
`endif
    out_ready = 1'b1;
    load_vals(v, 0);
    for (int c = 0; c <= N; c++) begin
      @(negedge clk); total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL basic_wait c=%0d got vld=%b rdy=%b exp 0 0", c, out_valid, in_ready);
      end
    end
    for (int j = 0; j < N; j++) begin
      @(negedge clk); total++;
      if ({out_valid, out_num, out_idx, out_last} !== {1'b1, e[j], CW'(j), j == N - 1}) begin
        bad++;
        $display("FAIL basic_out j=%0d got vld=%b num=%0d idx=%0d last=%b exp num=%0d",
                 j, out_valid, out_num, out_idx, out_last, e[j]);
      end
    end
    @(negedge clk); total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_done got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_gaps;
    v = '{6'd63, 6'd62, 6'd61, 6'd60, 6'd59};
`ifdef SERIAL_SORTER_DESC_EN
    e = '{6'd63, 6'd62, 6'd61, 6'd60, 6'd59};
`else
    e = '{6'd59, 6'd60, 6'd61, 6'd62, 6'd63};
`endif
    out_ready = 1'b1;
    load_vals(v, 1);
    for (int c = 0; c <= N; c++) begin
      @(negedge clk); total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL gaps_wait c=%0d got vld=%b rdy=%b exp 0 0", c, out_valid, in_ready);
      end
    end
    for (int j = 0; j < N; j++) begin
      @(negedge clk); total++;
      if ({in_ready, out_valid, out_num, out_idx, out_last} !==
          {1'b0, 1'b1, e[j], CW'(j), j == N - 1}) begin
        bad++;
        $display("FAIL gaps_out j=%0d got rdy=%b vld=%b num=%0d idx=%0d last=%b exp num=%0d",
                 j, in_ready, out_valid, out_num, out_idx, out_last, e[j]);
      end
    end
    @(negedge clk); total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL gaps_done got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int hs;
    int cyc;
    v = '{6'd3, 6'd1, 6'd5, 6'd2, 6'd4};
`ifdef SERIAL_SORTER_DESC_EN
    e = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
`else
    e = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
`endif
    out_ready = 1'b0;
    load_vals(v, 0);
    hs = 0; cyc = 0;
    while (hs < N && cyc < 60) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if ({out_num, out_idx, out_last} !== {e[hs], CW'(hs), hs == N - 1}) begin
          bad++;
          $display("FAIL bp_hold hs=%0d got num=%0d idx=%0d last=%b exp num=%0d idx=%0d",
                   hs, out_num, out_idx, out_last, e[hs], hs);
        end
        if (out_ready) hs++;
      end
      @(posedge clk); #1;
      out_ready = ~out_ready;
      cyc++;
    end
    total++;
    if (hs != N) begin
      bad++;
      $display("FAIL bp_count got handshakes=%0d exp %0d (timeout)", hs, N);
    end
    @(negedge clk); total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_done got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sort;
    v = '{6'd10, 6'd20, 6'd30, 6'd40, 6'd50};
    out_ready = 1'b1;
    load_vals(v, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1; total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_sort got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
`ifdef SERIAL_SORTER_DESC_EN
    e = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
`else
    e = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
`endif
    load_vals(v, 0);
    repeat (N + 1) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      @(negedge clk); total++;
      if ({out_valid, out_num, out_idx, out_last} !== {1'b1, e[j], CW'(j), j == N - 1}) begin
        bad++;
        $display("FAIL rst_reload j=%0d got vld=%b num=%0d idx=%0d last=%b exp num=%0d",
                 j, out_valid, out_num, out_idx, out_last, e[j]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_in_valid_flood;
    v = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    out_ready = 1'b1;
    load_vals(v, 0);
    in_valid = 1'b1;
    in_num   = 6'd7;
    repeat (N + 1) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      @(negedge clk); total++;
      if ({out_valid, out_num, out_idx, out_last} !== {1'b1, 6'd0, CW'(j), j == N - 1}) begin
        bad++;
        $display("FAIL flood_out j=%0d got vld=%b num=%0d idx=%0d last=%b exp num=0",
                 j, out_valid, out_num, out_idx, out_last);
      end
    end
    @(negedge clk); total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flood_done got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
    end
    // The held 7 is accepted on the first LOAD edge as element 0.
    @(posedge clk); #1;
    for (int i = 1; i < N; i++) begin
      in_num = W'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
`ifdef SERIAL_SORTER_DESC_EN
    e = '{6'd7, 6'd4, 6'd3, 6'd2, 6'd1};
`else
    e = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd7};
`endif
    repeat (N + 1) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      @(negedge clk); total++;
      if ({out_valid, out_num, out_idx, out_last} !== {1'b1, e[j], CW'(j), j == N - 1}) begin
        bad++;
        $display("FAIL flood_next j=%0d got vld=%b num=%0d idx=%0d last=%b exp num=%0d",
                 j, out_valid, out_num, out_idx, out_last, e[j]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_reset_mid_sort();
    test_in_valid_flood();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
